// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// for a shared-ALU, unified-memory datapath, stalling on mem_ready.
module multicycle_controller #(
  parameter int ALUOP_W  = 4,
  parameter int HALF_EN  = 1,
  parameter int WAIT_MAX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               half,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               retire,
  output logic               illegal,
  output logic               mem_timeout,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_EXEC_I  = 4'd4,
    S_WB_I    = 4'd5,
    S_ADDR    = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(9);

  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  state_t              state_q, state_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                wait_active;
  logic                r_alu_valid;
  logic [ALUOP_W-1:0]  r_alu_op;
  logic                is_link;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    r_alu_valid = 1'b1;
    r_alu_op    = ALU_ADD;
    case (funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_XOR:  r_alu_op = ALU_XOR;
      FN_NOR:  r_alu_op = ALU_NOR;
      FN_SLT:  r_alu_op = ALU_SLT;
      FN_SLL:  r_alu_op = ALU_SLL;
      FN_SRL:  r_alu_op = ALU_SRL;
      default: r_alu_valid = 1'b0;
    endcase
  end

  // jal and jalr both write the return address to r31 in their single retire cycle.
  assign is_link = (state_q == S_JUMP) ? (opcode == OP_JAL) : (funct == FN_JALR);

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    wait_d      = '0;
    wait_active = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    half        = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = '0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    retire      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'd1;
        alu_op      = ALU_ADD;
        wait_active = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        state_d   = S_TRAP;
        case (opcode)
          OP_RTYPE: begin
            if (r_alu_valid)                          state_d = S_EXEC_R;
            else if (funct == FN_JR || funct == FN_JALR) state_d = S_JR;
          end
          OP_ADDI, OP_ANDI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:              state_d = S_ADDR;
          OP_LH, OP_SH:              if (HALF_EN != 0) state_d = S_ADDR;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_J, OP_JAL:              state_d = S_JUMP;
          default:                   state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) illegal_d = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                    (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_SW || opcode == OP_SH) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read    = 1'b1;
        i_or_d      = 1'b1;
        half        = (opcode == OP_LH);
        wait_active = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write   = 1'b1;
        i_or_d      = 1'b1;
        half        = (opcode == OP_SH);
        wait_active = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'd1;
        pc_write  = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP, S_JR: begin
        pc_write = 1'b1;
        pc_src   = (state_q == S_JUMP) ? 2'd2 : 2'd3;
        retire   = 1'b1;
        if (is_link) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Stall accounting; a late mem_ready beats the timeout because it skips this path.
    if (wait_active && !mem_ready) begin
      if (WAIT_MAX > 0 && wait_q == WAIT_W'(WAIT_MAX)) begin
        state_d   = S_TRAP;
        timeout_d = 1'b1;
      end else if (wait_q != {WAIT_W{1'b1}}) begin
        wait_d = wait_q + WAIT_W'(1);
      end else begin
        wait_d = wait_q;
      end
    end

    // A mem_ready seen while reset is held must not load PC/IR.
    if (rst) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: three instances (default,
// HALF_EN=0, WAIT_MAX=3) share stimulus; expected controls are built per state.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       half;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       retire;
    logic       illegal;
    logic       mem_timeout;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    ctrl_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       ir_write_w [3];
  logic       pc_write_w [3];
  logic [1:0] pc_src_w [3];
  logic       i_or_d_w [3];
  logic       mem_read_w [3];
  logic       mem_write_w [3];
  logic       half_w [3];
  logic       alu_src_a_w [3];
  logic [1:0] alu_src_b_w [3];
  logic [3:0] alu_op_w [3];
  logic       reg_write_w [3];
  logic [1:0] reg_dst_w [3];
  logic [1:0] mem_to_reg_w [3];
  logic       retire_w [3];
  logic       illegal_w [3];
  logic       mem_timeout_w [3];
  logic [3:0] state_w [3];

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    multicycle_controller #(
      .ALUOP_W  (4),
      .HALF_EN  ((gi == 1) ? 0 : 1),
      .WAIT_MAX ((gi == 2) ? 3 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .funct       (funct),
      .alu_zero    (alu_zero),
      .mem_ready   (mem_ready),
      .ir_write    (ir_write_w[gi]),
      .pc_write    (pc_write_w[gi]),
      .pc_src      (pc_src_w[gi]),
      .i_or_d      (i_or_d_w[gi]),
      .mem_read    (mem_read_w[gi]),
      .mem_write   (mem_write_w[gi]),
      .half        (half_w[gi]),
      .alu_src_a   (alu_src_a_w[gi]),
      .alu_src_b   (alu_src_b_w[gi]),
      .alu_op      (alu_op_w[gi]),
      .reg_write   (reg_write_w[gi]),
      .reg_dst     (reg_dst_w[gi]),
      .mem_to_reg  (mem_to_reg_w[gi]),
      .retire      (retire_w[gi]),
      .illegal     (illegal_w[gi]),
      .mem_timeout (mem_timeout_w[gi]),
      .state       (state_w[gi])
    );
  end

  function automatic ctrl_t get(int k);
    ctrl_t r;
    r.state       = state_w[k];
    r.ir_write    = ir_write_w[k];
    r.pc_write    = pc_write_w[k];
    r.pc_src      = pc_src_w[k];
    r.i_or_d      = i_or_d_w[k];
    r.mem_read    = mem_read_w[k];
    r.mem_write   = mem_write_w[k];
    r.half        = half_w[k];
    r.alu_src_a   = alu_src_a_w[k];
    r.alu_src_b   = alu_src_b_w[k];
    r.alu_op      = alu_op_w[k];
    r.reg_write   = reg_write_w[k];
    r.reg_dst     = reg_dst_w[k];
    r.mem_to_reg  = mem_to_reg_w[k];
    r.retire      = retire_w[k];
    r.illegal     = illegal_w[k];
    r.mem_timeout = mem_timeout_w[k];
    return r;
  endfunction

  // Expected control words, one builder per state.
  function automatic ctrl_t blank(logic [3:0] st);
    ctrl_t r = '0;
    r.state = st;
    return r;
  endfunction

  function automatic ctrl_t e_fetch(logic rdy);
    ctrl_t r = blank(4'd0);
    r.mem_read = 1'b1; r.alu_src_b = 2'd1; r.alu_op = 4'd1;
    r.ir_write = rdy;  r.pc_write = rdy;
    return r;
  endfunction

  function automatic ctrl_t e_decode();
    ctrl_t r = blank(4'd1);
    r.alu_src_b = 2'd3; r.alu_op = 4'd1;
    return r;
  endfunction

  function automatic ctrl_t e_exec(logic [3:0] st, logic [1:0] srcb, logic [3:0] aop);
    ctrl_t r = blank(st);
    r.alu_src_a = 1'b1; r.alu_src_b = srcb; r.alu_op = aop;
    return r;
  endfunction

  function automatic ctrl_t e_wb(logic [3:0] st, logic [1:0] dst, logic [1:0] m2r);
    ctrl_t r = blank(st);
    r.reg_write = 1'b1; r.reg_dst = dst; r.mem_to_reg = m2r; r.retire = 1'b1;
    return r;
  endfunction

  function automatic ctrl_t e_mem(logic wr, logic hf, logic rdy);
    ctrl_t r = blank(wr ? 4'd8 : 4'd7);
    r.i_or_d = 1'b1; r.half = hf;
    if (wr) begin r.mem_write = 1'b1; r.retire = rdy; end
    else r.mem_read = 1'b1;
    return r;
  endfunction

  function automatic ctrl_t e_branch(logic taken);
    ctrl_t r = e_exec(4'd10, 2'd0, 4'd2);
    r.pc_src = 2'd1; r.pc_write = taken; r.retire = 1'b1;
    return r;
  endfunction

  function automatic ctrl_t e_jump(logic [3:0] st, logic [1:0] src, logic link);
    ctrl_t r = blank(st);
    r.pc_write = 1'b1; r.pc_src = src; r.retire = 1'b1;
    if (link) begin r.reg_write = 1'b1; r.reg_dst = 2'd2; r.mem_to_reg = 2'd2; end
    return r;
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input ctrl_t exp);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic r_seq(input logic [5:0] fn, input logic [3:0] aop);
    add(6'h00, fn, 1'b0, 1'b1, e_fetch(1'b1));
    add(6'h00, fn, 1'b0, 1'b1, e_decode());
    add(6'h00, fn, 1'b0, 1'b1, e_exec(4'd2, 2'd0, aop));
    add(6'h00, fn, 1'b0, 1'b1, e_wb(4'd3, 2'd1, 2'd0));
  endtask

  task automatic i_seq(input logic [5:0] op, input logic [3:0] aop);
    add(op, 6'h15, 1'b0, 1'b1, e_fetch(1'b1));
    add(op, 6'h15, 1'b0, 1'b1, e_decode());
    add(op, 6'h15, 1'b0, 1'b1, e_exec(4'd4, 2'd2, aop));
    add(op, 6'h15, 1'b0, 1'b1, e_wb(4'd5, 2'd0, 2'd0));
  endtask

  task automatic load_seq(input logic [5:0] op, input logic hf);
    add(op, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add(op, 6'h00, 1'b0, 1'b1, e_decode());
    add(op, 6'h00, 1'b0, 1'b1, e_exec(4'd6, 2'd2, 4'd1));
    add(op, 6'h00, 1'b0, 1'b0, e_mem(1'b0, hf, 1'b0));
    add(op, 6'h00, 1'b0, 1'b0, e_mem(1'b0, hf, 1'b0));
    add(op, 6'h00, 1'b0, 1'b1, e_mem(1'b0, hf, 1'b1));
    add(op, 6'h00, 1'b0, 1'b1, e_wb(4'd9, 2'd0, 2'd1));
  endtask

  task automatic branch_seq(input logic [5:0] op, input logic z, input logic taken);
    add(op, 6'h00, z, 1'b1, e_fetch(1'b1));
    add(op, 6'h00, z, 1'b1, e_decode());
    add(op, 6'h00, z, 1'b1, e_branch(taken));
  endtask

  task automatic jump_seq(input logic [5:0] op, input logic [5:0] fn, input ctrl_t last);
    add(op, fn, 1'b0, 1'b1, e_fetch(1'b1));
    add(op, fn, 1'b0, 1'b1, e_decode());
    add(op, fn, 1'b0, 1'b1, last);
  endtask

  task automatic chk_ctrl(input string name, input ctrl_t got, input ctrl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d ctrl=%h, want state=%0d ctrl=%h",
               name, got.state, got, exp.state, exp);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Returns at a negedge with rst just released and mem_ready = rdy.
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = rdy;
    #1;
    for (int k = 0; k < 3; k++) chk_ctrl($sformatf("reset_inst%0d", k), get(k), e_fetch(1'b0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    r_seq(6'h20, 4'd1);  r_seq(6'h22, 4'd2);  r_seq(6'h24, 4'd3);
    r_seq(6'h25, 4'd4);  r_seq(6'h26, 4'd5);  r_seq(6'h27, 4'd6);
    r_seq(6'h2A, 4'd7);  r_seq(6'h00, 4'd8);  r_seq(6'h02, 4'd9);
    i_seq(6'h08, 4'd1);  i_seq(6'h0C, 4'd3);  i_seq(6'h0A, 4'd7);
    load_seq(6'h23, 1'b0);
    load_seq(6'h21, 1'b1);
    add(6'h2B, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add(6'h2B, 6'h00, 1'b0, 1'b1, e_decode());
    add(6'h2B, 6'h00, 1'b0, 1'b1, e_exec(4'd6, 2'd2, 4'd1));
    add(6'h2B, 6'h00, 1'b0, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
    add(6'h2B, 6'h00, 1'b0, 1'b1, e_mem(1'b1, 1'b0, 1'b1));
    add(6'h29, 6'h00, 1'b0, 1'b1, e_fetch(1'b1));
    add(6'h29, 6'h00, 1'b0, 1'b1, e_decode());
    add(6'h29, 6'h00, 1'b0, 1'b1, e_exec(4'd6, 2'd2, 4'd1));
    add(6'h29, 6'h00, 1'b0, 1'b1, e_mem(1'b1, 1'b1, 1'b1));
    add(6'h04, 6'h00, 1'b1, 1'b0, e_fetch(1'b0));
    add(6'h04, 6'h00, 1'b1, 1'b0, e_fetch(1'b0));
    branch_seq(6'h04, 1'b1, 1'b1);
    branch_seq(6'h05, 1'b1, 1'b0);
    branch_seq(6'h04, 1'b0, 1'b0);
    branch_seq(6'h05, 1'b0, 1'b1);
    jump_seq(6'h02, 6'h00, e_jump(4'd11, 2'd2, 1'b0));
    jump_seq(6'h03, 6'h00, e_jump(4'd11, 2'd2, 1'b1));
    jump_seq(6'h00, 6'h08, e_jump(4'd12, 2'd3, 1'b0));
    jump_seq(6'h00, 6'h09, e_jump(4'd12, 2'd3, 1'b1));

    do_reset(1'b1);
    foreach (vecs[i]) begin
      opcode = vecs[i].op; funct = vecs[i].fn;
      alu_zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      chk_ctrl($sformatf("vec%0d_op%02h_fn%02h", i, vecs[i].op, vecs[i].fn), get(0), vecs[i].exp);
      @(negedge clk);
    end

    // Illegal opcode: absorbing trap, then asynchronous reset in mid-cycle.
    opcode = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
    @(negedge clk);
    chk("ill_decode_state", 8'(state_w[0]), 8'd1);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      ctrl_t t = blank(4'd13);
      t.illegal = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      #1;
      chk_ctrl($sformatf("trap_hold%0d", c), get(0), t);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_ctrl("async_rst_from_trap", get(0), e_fetch(1'b0));
    @(negedge clk);
    rst = 1'b0;

    // R-type with an unknown funct also traps.
    opcode = 6'h00; funct = 6'h3F;
    @(negedge clk); @(negedge clk);
    chk("bad_funct_state", 8'(state_w[0]), 8'd13);
    chk("bad_funct_illegal", 8'(illegal_w[0]), 8'd1);

    // Halfword accesses trap when HALF_EN=0.
    do_reset(1'b1);
    opcode = 6'h29; funct = 6'h00;
    @(negedge clk); @(negedge clk);
    chk("sh_half0_state", 8'(state_w[1]), 8'd13);
    chk("sh_half0_illegal", 8'(illegal_w[1]), 8'd1);
    chk("sh_half1_state", 8'(state_w[0]), 8'd6);
    do_reset(1'b1);
    opcode = 6'h21;
    @(negedge clk); @(negedge clk);
    chk("lh_half0_state", 8'(state_w[1]), 8'd13);

    // WAIT_MAX=3 in FETCH: trap on the 4th edge.
    do_reset(1'b0);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      chk($sformatf("wait_edge%0d_state", e), 8'(state_w[2]), 8'd0);
      chk($sformatf("wait_edge%0d_tmo", e), 8'(mem_timeout_w[2]), 8'd0);
    end
    @(negedge clk);
    chk("timeout_state", 8'(state_w[2]), 8'd13);
    chk("timeout_flag", 8'(mem_timeout_w[2]), 8'd1);
    chk("timeout_not_illegal", 8'(illegal_w[2]), 8'd0);
    chk("unbounded_still_fetch", 8'(state_w[0]), 8'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("timeout_sticky", 8'(mem_timeout_w[2]), 8'd1);

    // mem_ready on the 3rd wait cycle completes the fetch.
    do_reset(1'b0);
    opcode = 6'h00; funct = 6'h20;
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("late_ready_ir_write", 8'(ir_write_w[2]), 8'd1);
    @(negedge clk);
    chk("late_ready_state", 8'(state_w[2]), 8'd1);
    chk("late_ready_no_tmo", 8'(mem_timeout_w[2]), 8'd0);

    // Reset during WB_R aborts the write-back.
    do_reset(1'b1);
    opcode = 6'h00; funct = 6'h20;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("wb_r_retire", 8'(retire_w[0]), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_retire", 8'(retire_w[0]), 8'd0);
    chk("abort_reg_write", 8'(reg_write_w[0]), 8'd0);
    chk("abort_state", 8'(state_w[0]), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the shared-ALU/shared-memory datapath one step per cycle. It stalls on a memory ready handshake, with an optional wait-state timeout. It sits between the instruction register (opcode/funct) and the datapath muxes, register file, ALU and unified memory.

## Interface
- ALUOP_W, 4: alu_op width; encoding nop0 add1 sub2 and3 or4 xor5 nor6 slt7 sll8 srl9 beq10 bne11.
- HALF_EN, 1: 1 = lh/sh legal; 0 = lh/sh decode as illegal.
- WAIT_MAX, 0: max cycles waiting for mem_ready; 0 = unbounded.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write, pc_write  out  1  register load enables.
- pc_src  out  2  PC+4 / branch target / jump target / rs.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALU out.
- mem_read, mem_write, half  out  1  memory strobes; half selects a halfword access.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  rt / 4 / sign-ext imm / imm<<2.
- alu_op  out  ALUOP_W  ALU control.
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  rt / rd / 31.
- mem_to_reg  out  2  ALU out / MDR / PC.
- retire  out  1  one-cycle pulse on an instruction's last cycle.
- illegal, mem_timeout  out  1  sticky trap flags.
- state  out  4  current state encoding.

## Operation
- States: FETCH0, DECODE1, EXEC_R2, WB_R3, EXEC_I4, WB_I5, ADDR6, MEM_RD7, MEM_WR8, WB_MEM9, BRANCH10, JUMP11, JR12, TRAP13.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1 (4), alu_op=add.
  - When mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise: stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target). Dispatch:
  - R-type add/sub/and/or/xor/nor/slt/sll/srl go to EXEC_R.
  - addi/andi/slti go to EXEC_I.
  - lw/lh/sw/sh go to ADDR.
  - beq/bne go to BRANCH.
  - j/jal go to JUMP.
  - jr/jalr go to JR.
  - Anything else goes to TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op per funct. WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op add/and/slt. WB_I: reg_write=1, reg_dst=0, retire=1.
- ADDR: alu_src_a=1, alu_src_b=2, alu_op=add. Next state is MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_read=1, i_or_d=1, half=(lh). When mem_ready, go to WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1.
- MEM_WR: mem_write=1, i_or_d=1, half=(sh). When mem_ready, retire=1 and go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_src=1, retire=1.
  - pc_write = (beq & alu_zero) | (bne & !alu_zero). This is combinational on alu_zero.
- JUMP: pc_write=1, pc_src=2, retire=1. For jal also reg_write=1, reg_dst=2, mem_to_reg=2.
- JR: pc_write=1, pc_src=3, retire=1. For jalr also reg_write=1, reg_dst=2, mem_to_reg=2.
- After the retire cycle, the next state is always FETCH.
- TRAP: all strobes 0. The state is absorbing until rst.
  - Entered from DECODE: illegal=1.
  - Entered via timeout: mem_timeout=1.
- opcode/funct are sampled only in DECODE and in the state that uses them. The datapath holds IR stable.
- Unlisted outputs in each state are 0.

## Timing
- Reset (asynchronous): state=FETCH; illegal=0, mem_timeout=0, wait counter=0. All outputs take FETCH values immediately; pc_write and ir_write stay 0 until mem_ready.
- Releasing rst does not complete any access. A mem_ready that was high during reset is honored only on the first clock edge after release.
- Reset mid-instruction aborts it: no retire, no write enable after the reset asserts.
- Outputs are Moore from state. Exceptions: FETCH pc_write/ir_write gated by mem_ready, BRANCH pc_write gated by alu_zero, MEM_WR retire gated by mem_ready.
- Cycles per instruction with mem_ready held high: R 4, I 4, lw/lh 5, sw/sh 4, branch 3, j/jal/jr/jalr 3. Each wait cycle adds 1.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears to 0 on mem_ready or on leaving those states.
  - If WAIT_MAX>0 and the count reaches WAIT_MAX, the next state is TRAP with mem_timeout=1.
  - mem_ready arriving on the cycle the count would reach WAIT_MAX wins: the access completes normally.

## Test plan
- Reset with mem_ready=1: add (000000/100000) gives states 0,1,2,3,0. alu_op=1 in EXEC_R; reg_write=1, reg_dst=1, retire=1 in WB_R; 4 cycles total.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD: 7 cycles. mem_to_reg=1 and reg_write=1 only in WB_MEM; half=0. lh repeats with half=1.
- beq: alu_zero=1 gives pc_write=1, pc_src=1. bne with alu_zero=1 gives pc_write=0; retire=1 in both; 3 cycles each.
- jal: JUMP asserts pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. jalr (funct 001001): JR asserts pc_src=3 and the same register-file controls.
- Opcode 111111 gives TRAP and illegal=1 held for 20 cycles. With HALF_EN=0, sh traps. rst asserted mid-TRAP clears illegal asynchronously and goes to FETCH.
- WAIT_MAX=3 with mem_ready=0 in FETCH: TRAP on the 4th edge, mem_timeout=1. mem_ready=1 on the 3rd wait cycle gives a normal fetch, no trap.
